regfile_wb_scheduler: RTL and testbench

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

---
 rtl/regfile_pkg.sv | 14 +
 rtl/wb_scoreboard.sv | 52 +++++
 rtl/regfile_wb_scheduler.sv | 121 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, register-address type and write-back grant encoding
package regfile_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_t;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register busy bits with issue set, write-back clear, flush and hazard query
module wb_scoreboard #(
    parameter int NREGS = regfile_pkg::NREGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [4:0]       set_idx,
    input  logic             clr_en,
    input  logic [4:0]       clr_idx,
    input  logic             flush,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    output logic [NREGS-1:0] busy,
    output logic             hazard
);
    import regfile_pkg::*;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (clr_en) begin
                busy_d[clr_idx] = 1'b0;
            end
            // Applied after the clear so a same-edge set/clear of one index leaves it busy.
            if (set_en) begin
                busy_d[set_idx] = 1'b1;
            end
        end
        // x0 is never tracked, so it can never block an issue.
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Registered state only: a write-back landing this cycle does not unblock until next cycle.
    assign hazard = busy_q[rs1] | busy_q[rs2] | busy_q[rd];
    assign busy   = busy_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - ALU/LSU write-back arbiter and register-file write drive; scoreboard enabled by REGFILE_WB_SCOREBOARD_EN
module regfile_wb_scheduler #(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int NREGS = regfile_pkg::NREGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [4:0]       lsu_rd,
    input  logic [XLEN-1:0]  lsu_data,
    output logic             w_enable,
    output logic [4:0]       w_address,
    output logic [XLEN-1:0]  w_data,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [4:0]       iss_rd,
    input  logic [4:0]       iss_rs1,
    input  logic [4:0]       iss_rs2,
    input  logic             flush,
    output logic [NREGS-1:0] busy
);
    import regfile_pkg::*;

    grant_t          last_grant_q;
    grant_t          last_grant_d;
    logic            w_enable_q;
    logic            w_enable_d;
    reg_addr_t       w_address_q;
    reg_addr_t       w_address_d;
    logic [XLEN-1:0] w_data_q;
    logic [XLEN-1:0] w_data_d;
    logic            alu_acc;
    logic            lsu_acc;

    // On a tie the source that did not win last time gets the slot.
    always_comb begin
        alu_ready = alu_valid && (!lsu_valid || (last_grant_q == GRANT_LSU));
        lsu_ready = lsu_valid && (!alu_valid || (last_grant_q == GRANT_ALU));
    end

    assign alu_acc = alu_valid && alu_ready;
    assign lsu_acc = lsu_valid && lsu_ready;

    // An accepted x0 write still rotates the grant but never reaches the write port.
    always_comb begin
        last_grant_d = last_grant_q;
        w_enable_d   = 1'b0;
        w_address_d  = w_address_q;
        w_data_d     = w_data_q;
        if (alu_acc) begin
            last_grant_d = GRANT_ALU;
            if (alu_rd != 5'd0) begin
                w_enable_d  = 1'b1;
                w_address_d = alu_rd;
                w_data_d    = alu_data;
            end
        end else if (lsu_acc) begin
            last_grant_d = GRANT_LSU;
            if (lsu_rd != 5'd0) begin
                w_enable_d  = 1'b1;
                w_address_d = lsu_rd;
                w_data_d    = lsu_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_LSU;
            w_enable_q   <= 1'b0;
            w_address_q  <= '0;
            w_data_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            w_enable_q   <= w_enable_d;
            w_address_q  <= w_address_d;
            w_data_q     <= w_data_d;
        end
    end

    assign w_enable  = w_enable_q;
    assign w_address = w_address_q;
    assign w_data    = w_data_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic hazard;
    logic iss_set;

    assign iss_ready = !flush && !hazard;
    assign iss_set   = iss_valid && iss_ready && (iss_rd != 5'd0);

    wb_scoreboard #(
        .NREGS (NREGS)
    ) u_wb_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (iss_set),
        .set_idx (iss_rd),
        .clr_en  (w_enable_q),
        .clr_idx (w_address_q),
        .flush   (flush),
        .rs1     (iss_rs1),
        .rs2     (iss_rs2),
        .rd      (iss_rd),
        .busy    (busy),
        .hazard  (hazard)
    );
`else
    logic unused_iss;

    assign busy       = '0;
    assign iss_ready  = !flush;
    assign unused_iss = ^{iss_valid, iss_rd, iss_rs1, iss_rs2};
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - self-checking bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        w_enable;
    logic [4:0]  w_address;
    logic [31:0] w_data;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic        flush;
    logic [31:0] busy;

    regfile_wb_scheduler #(.XLEN(32), .NREGS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .w_enable  (w_enable),
        .w_address (w_address),
        .w_data    (w_data),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .flush     (flush),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        exp_ar;
        logic        exp_lr;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vec[13];
    wr_t  sbq[$];
    wr_t  last_wr;
    wr_t  got;
    logic exp_wen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
        flush = 1'b0;
        last_wr = '{5'd0, 32'h0};

        vec[0]  = '{1'b1, 5'd3,  32'h3333_0001, 1'b1, 5'd4,  32'h4444_0001, 1'b1, 1'b0};
        vec[1]  = '{1'b1, 5'd3,  32'h3333_0002, 1'b1, 5'd4,  32'h4444_0002, 1'b0, 1'b1};
        vec[2]  = '{1'b1, 5'd3,  32'h3333_0003, 1'b1, 5'd4,  32'h4444_0003, 1'b1, 1'b0};
        vec[3]  = '{1'b1, 5'd3,  32'h3333_0004, 1'b1, 5'd4,  32'h4444_0004, 1'b0, 1'b1};
        vec[4]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
        vec[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
        vec[6]  = '{1'b1, 5'd0,  32'h0000_0001, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
        vec[7]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 32'h1234_5678, 1'b0, 1'b1};
        vec[8]  = '{1'b1, 5'd0,  32'h0000_0002, 1'b1, 5'd11, 32'hBBBB_000B, 1'b1, 1'b0};
        vec[9]  = '{1'b1, 5'd0,  32'h0000_0002, 1'b1, 5'd11, 32'hBBBB_000B, 1'b0, 1'b1};
        vec[10] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
        vec[11] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b1};
        vec[12] = '{1'b1, 5'd1,  32'h0000_0000, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};

        // Reset state and combinational ready while held in reset.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_w_enable", {31'd0, w_enable}, 32'd0);
        chk("rst_w_address", {27'd0, w_address}, 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2222_2222;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h6666_6666;
        #1;
        chk("rst_alu_ready_tie", {31'd0, alu_ready}, 32'd1);
        chk("rst_lsu_ready_tie", {31'd0, lsu_ready}, 32'd0);
        tick();
        chk("rst_no_accept", {31'd0, w_enable}, 32'd0);
        @(negedge clk);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_w_enable", {31'd0, w_enable}, 32'd0);

        // Table-driven arbitration and write drive.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            alu_valid = vec[i].av; alu_rd = vec[i].ard; alu_data = vec[i].adata;
            lsu_valid = vec[i].lv; lsu_rd = vec[i].lrd; lsu_data = vec[i].ldata;
            #1;
            chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vec[i].exp_ar});
            chk($sformatf("v%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, vec[i].exp_lr});
            exp_wen = 1'b0;
            if (vec[i].exp_ar && vec[i].ard != 5'd0) begin
                sbq.push_back('{vec[i].ard, vec[i].adata});
                exp_wen = 1'b1;
            end else if (vec[i].exp_lr && vec[i].lrd != 5'd0) begin
                sbq.push_back('{vec[i].lrd, vec[i].ldata});
                exp_wen = 1'b1;
            end
            tick();
            chk($sformatf("v%0d_w_enable", i), {31'd0, w_enable}, {31'd0, exp_wen});
            if (w_enable === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("v%0d_spurious_write", i), {31'd0, w_enable}, 32'd0);
                end else begin
                    got = sbq.pop_front();
                    chk($sformatf("v%0d_w_address", i), {27'd0, w_address}, {27'd0, got.addr});
                    chk($sformatf("v%0d_w_data", i), w_data, got.data);
                    last_wr = got;
                end
            end else if (!vec[i].exp_ar && !vec[i].exp_lr) begin
                chk($sformatf("v%0d_hold_address", i), {27'd0, w_address}, {27'd0, last_wr.addr});
                chk($sformatf("v%0d_hold_data", i), w_data, last_wr.data);
            end
            chk($sformatf("v%0d_busy", i), busy, 32'd0);
            chk($sformatf("v%0d_iss_ready", i), {31'd0, iss_ready}, 32'd1);
        end
        chk("sb_drained", sbq.size(), 32'd0);

        // Issue rd=7, dependent issue on rs1=7 waits for the write-back of x7.
        @(negedge clk);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd7; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        #1 chk("raw_first_issue_ready", {31'd0, iss_ready}, 32'd1);
        tick();
        chk("raw_busy7", busy, SB ? 32'h0000_0080 : 32'd0);
        @(negedge clk);
        iss_rd = 5'd8; iss_rs1 = 5'd7;
        #1 chk("raw_stall_0", {31'd0, iss_ready}, SB ? 32'd0 : 32'd1);
        tick();
        chk("raw_busy7_held", busy, SB ? 32'h0000_0080 : 32'd0);
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hCAFE_0007;
        #1 chk("raw_stall_1", {31'd0, iss_ready}, SB ? 32'd0 : 32'd1);
        tick();
        chk("raw_w_enable", {31'd0, w_enable}, 32'd1);
        chk("raw_w_address", {27'd0, w_address}, 32'd7);
        chk("raw_w_data", w_data, 32'hCAFE_0007);
        @(negedge clk);
        alu_valid = 1'b0;
        #1 chk("raw_stall_during_wen", {31'd0, iss_ready}, SB ? 32'd0 : 32'd1);
        tick();
        chk("raw_w_enable_off", {31'd0, w_enable}, 32'd0);
        chk("raw_busy_cleared", busy, 32'd0);
        @(negedge clk);
        #1 chk("raw_ready_after_wen", {31'd0, iss_ready}, 32'd1);
        tick();
        chk("raw_busy8", busy, SB ? 32'h0000_0100 : 32'd0);

        // Write-back to a non-busy register, then same-edge set and clear of x5.
        @(negedge clk);
        iss_valid = 1'b0; iss_rs1 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h5555_0005;
        tick();
        chk("nb_w_enable", {31'd0, w_enable}, 32'd1);
        chk("nb_busy_unchanged", busy, SB ? 32'h0000_0100 : 32'd0);
        @(negedge clk);
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd5;
        #1 chk("sw_iss_ready", {31'd0, iss_ready}, 32'd1);
        chk("sw_w_address", {27'd0, w_address}, 32'd5);
        tick();
        chk("set_wins_busy", busy, SB ? 32'h0000_0120 : 32'd0);

        // Flush clears busy while a pending LSU write to x9 still drives.
        @(negedge clk);
        iss_rd = 5'd9;
        tick();
        @(negedge clk);
        iss_rd = 5'd12;
        tick();
        chk("fl_busy_before", busy, SB ? 32'h0000_1320 : 32'd0);
        @(negedge clk);
        iss_valid = 1'b0; flush = 1'b1;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9999_0009;
        #1;
        chk("fl_iss_ready", {31'd0, iss_ready}, 32'd0);
        chk("fl_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        tick();
        chk("fl_busy_cleared", busy, 32'd0);
        chk("fl_w_enable", {31'd0, w_enable}, 32'd1);
        chk("fl_w_address", {27'd0, w_address}, 32'd9);
        chk("fl_w_data", w_data, 32'h9999_0009);
        @(negedge clk);
        flush = 1'b0; lsu_valid = 1'b0;
        #1 chk("fl_iss_ready_after", {31'd0, iss_ready}, 32'd1);
        tick();
        chk("fl_busy_after", busy, 32'd0);

        // Asynchronous reset while a write is being driven.
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'hA5A5_5A5A;
        iss_valid = 1'b1; iss_rd = 5'd13;
        tick();
        chk("ar_w_enable", {31'd0, w_enable}, 32'd1);
        chk("ar_busy_before", busy, SB ? 32'h0000_2000 : 32'd0);
        #2 rst_n = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd22; lsu_data = 32'h2222_0022;
        #1;
        chk("ar_w_enable_0", {31'd0, w_enable}, 32'd0);
        chk("ar_w_address_0", {27'd0, w_address}, 32'd0);
        chk("ar_w_data_0", w_data, 32'd0);
        chk("ar_busy_0", busy, 32'd0);
        chk("ar_alu_ready_tie", {31'd0, alu_ready}, 32'd1);
        chk("ar_lsu_ready_tie", {31'd0, lsu_ready}, 32'd0);
        tick();
        chk("ar_no_accept", {31'd0, w_enable}, 32'd0);
        @(negedge clk);
        alu_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("ar_post_w_enable", {31'd0, w_enable}, 32'd0);
        chk("ar_post_busy", busy, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
